// File: rtl/edge_reporter_if.sv
// edge_reporter_if: event record handshake between edge_reporter (master)
// and its consumer (slave).
//   event_data  : {polarity, timestamp}; polarity 1 = rising, 0 = falling
//   event_valid : head record present (FIFO non-empty)
//   event_ready : consumer accepts the head record this cycle
interface edge_reporter_if #(
    parameter int timestamp_width = 16
);
    logic [timestamp_width:0] event_data;
    logic                     event_valid;
    logic                     event_ready;

    modport master (
        output event_data,
        output event_valid,
        input  event_ready
    );

    modport slave (
        input  event_data,
        input  event_valid,
        output event_ready
    );
endinterface

// File: rtl/edge_reporter.sv
// edge_reporter: turns edges of a qualified (debounced) level into
// timestamped event records, buffered in a show-ahead FIFO.
//   clock, reset    : clock; asynchronous active-high reset
//   enable          : timestamp tick strobe
//   in, in_valid    : debounced level and its qualifier
//   level           : last accepted level
//   overflow        : sticky, set when a record is dropped on a full FIFO
//   clear_overflow  : clears overflow (a simultaneous drop wins)
//   evt_bus         : record handshake (data / valid / ready)
module edge_reporter #(
    parameter int timestamp_width = 16,
    parameter int depth           = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            in,
    input  logic            in_valid,
    output logic            level,
    output logic            overflow,
    input  logic            clear_overflow,
    edge_reporter_if.master evt_bus
);
    localparam int ptr_width   = (depth > 1) ? $clog2(depth) : 1;
    localparam int count_width = ptr_width + 1;

    logic                       armed_reg;
    logic                       level_reg;
    logic                       overflow_reg;
    logic [timestamp_width-1:0] ts_reg;
    logic [ptr_width-1:0]       wr_ptr_reg;
    logic [ptr_width-1:0]       rd_ptr_reg;
    logic [count_width-1:0]     count_reg;
    logic [timestamp_width:0]   mem [depth];

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    always_comb begin
        push_req = in_valid & armed_reg & (in != level_reg);
        pop      = (count_reg != '0) & evt_bus.event_ready;
        full     = (count_reg == count_width'(depth));
        // A pop in the same cycle frees the slot the push needs.
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_reg    <= 1'b0;
            level_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            ts_reg       <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (enable) begin
                ts_reg <= ts_reg + timestamp_width'(1);
            end

            // First qualified sample only establishes the baseline level.
            if (in_valid) begin
                armed_reg <= 1'b1;
                level_reg <= in;
            end

            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end

            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_width'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_width'(1);
            end

            unique case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + count_width'(1);
                2'b01:   count_reg <= count_reg - count_width'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage has no reset: contents are don't-care while unoccupied.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= {in, ts_reg};
        end
    end

    // Show-ahead: the head entry is always presented.
    assign evt_bus.event_data  = mem[rd_ptr_reg];
    assign evt_bus.event_valid = (count_reg != '0);
    assign level               = level_reg;
    assign overflow            = overflow_reg;
endmodule

// File: doc/edge_reporter.md
# edge_reporter

Downstream consumer of the stretcher (debounce) stage. It watches the debounced level and its `valid` qualifier and turns every rising or falling edge into a timestamped event record. Records are buffered in a small show-ahead FIFO and handed to software/bus logic over a valid/ready handshake. Lost events are reported through a sticky overflow flag.

## Interface
- `timestamp_width`, default 16: width of the free-running timestamp counter; minimum 1.
- `depth`, default 4: FIFO entries; power of two, minimum 2.

- `clock`  input  1: clock.
- `reset`  input  1: asynchronous, active-high.
- `enable`  input  1: timestamp tick; the same strobe that drives the stretcher's `enable`.
- `in`  input  1: debounced level (stretcher `out`).
- `in_valid`  input  1: level qualifier (stretcher `valid`).
- `level`  output  1: last accepted level.
- `event_data`  output  timestamp_width+1: {polarity, timestamp}; polarity 1 = rising, 0 = falling.
- `event_valid`  output  1: FIFO non-empty.
- `event_ready`  input  1: consumer accepts the head record.
- `overflow`  output  1: sticky, set when an event is dropped.
- `clear_overflow`  input  1: clears `overflow`.

## Operation
- Reset values: `level`=0, `event_valid`=0, `overflow`=0; internal `armed`=0, timestamp=0, FIFO empty. `event_data` is don't-care whenever `event_valid`=0, including after reset.
- Timestamp: increments by 1 on every clock with `enable`=1 and wraps modulo 2^timestamp_width. An event carries the counter value present in its detection cycle, before that cycle's increment.
- Arming: the first cycle with `in_valid`=1 and `armed`=0 loads `level`<=`in` and sets `armed`. No event is produced; the initial level is not an edge.
- Detection: a cycle with `in_valid`=1, `armed`=1 and `in`!=`level` is an edge. `level`<=`in`, and the record {`in`, timestamp} is pushed.
- When `in_valid`=0, `in` is ignored and `level` holds. `armed` stays set once set; only reset clears it.
- Pop: `event_valid`&`event_ready` removes the head. The next entry appears on `event_data` the following cycle.
- Push when full:
  - Full with a pop in the same cycle: the push is accepted and count is unchanged.
  - Full without a pop: the record is dropped, `overflow` is set, and `level` still updates.
- `overflow`: cleared by `clear_overflow`=1. If a set and a clear occur in the same cycle, set wins.
- Push into an empty FIFO with a simultaneous `event_ready`: no pop, since `event_valid` was 0 that cycle.
- Order is strictly FIFO. Read and write pointers wrap modulo `depth`. Occupancy is tracked with a `log2(depth)+1`-bit count, or with extra-MSB pointers.

## Timing
- Edge sampled at clock edge k: `event_valid`=1 and the record visible after edge k (1-cycle latency) if the FIFO was empty.
- Pop at edge k: the next head is valid after edge k. `event_valid` falls after edge k if that pop was the last entry.
- Throughput: one push and one pop per cycle. Back-to-back edges on consecutive cycles are all captured until full.
- `overflow` asserts after the edge at which the drop occurs.
- Asynchronous reset mid-operation: the FIFO empties, `armed` clears, and `overflow`/timestamp zero immediately. Pending records are lost. The first `in_valid` cycle after reset re-arms without producing an event.

## Test plan
- Arm without event: reset, `in`=1, `in_valid`=1 for 3 cycles. Expect `level`=1, `event_valid` stays 0.
- Timestamped edges:
  - Arm at level 0 with `enable`=1 every cycle.
  - Raise `in` when timestamp=5. Expect record {1, 5} one cycle later.
  - Drop `in` when timestamp=9. Expect a second record {0, 9} behind the first.
- Gating: toggle `in` while `in_valid`=0. Expect no records and `level` unchanged. Restore `in_valid`=1 with `in`!=`level`. Expect exactly one record.
- Overflow (`depth`=4, `event_ready`=0):
  - 5 edges: 4 records stored, 5th dropped, `overflow`=1.
  - Assert `clear_overflow` together with a 6th edge: `overflow` stays 1.
  - Pulse `clear_overflow` alone: `overflow`=0.
- Full with simultaneous pop: FIFO full, edge and `event_ready`=1 in the same cycle. Expect no overflow, count stays 4, order preserved.
- Wrap (`timestamp_width`=4): edge at timestamp 15, next edge 2 ticks later. Expect timestamps 15 then 1.
